frv_masked_rng_bank: RTL and testbench
======================================

Name: frv_masked_rng_bank

Overview:
- Fresh-randomness source sitting directly upstream of the masked Boolean ALU wrapper. Drives its six 32-bit randomness inputs z0..z5.
- Holds six independent 32-bit Galois LFSR lanes, seeded over a word-serial handshake.
- Presents one complete randomness set per operation and never presents the same set twice.
- Counts consumed sets and requests a reseed after a programmable interval.

Parameters:
- BIT_WIDTH, 32, width of each lane and each z output; fixed at 32 for this block.
- RESEED_INTERVAL, 1024, number of consumed sets after which reseed_req asserts; legal range 1..65535.
- LFSR_MASK, 32'h80200003, Galois feedback mask (polynomial x^32+x^22+x^2+x+1).

Ports:
- g_clk  input  1  clock.
- g_resetn  input  1  synchronous active-low reset.
- flush  input  1  discard the currently presented set.
- seed_valid  input  1  seed word valid.
- seed  input  32  seed word.
- seed_ready  output  1  block accepts a seed word.
- rnd_req  input  1  consumer takes the current set this cycle.
- rnd_valid  output  1  z0..z5 hold a fresh, unconsumed set.
- z0..z5  output  32 each  randomness words (six ports).
- reseed_req  output  1  consumed-set count reached RESEED_INTERVAL.

Behaviour:
- Interface: one clock, g_clk. Reset is synchronous and active-low on g_resetn, sampled on the g_clk rising edge. Reset mid-operation returns everything to the reset state; a partially loaded seed is discarded.
- Reset state:
  - FSM in UNSEEDED; lanes, seed-beat counter and use counter all zero.
  - Outputs: rnd_valid=0, seed_ready=0, reseed_req=0, z0..z5=0.
- Lane step: 32 unrolled Galois iterations, applied combinationally in one cycle.
  - Each iteration: if bit0=1 then s=(s>>1)^LFSR_MASK, else s=s>>1.
  - All six lanes step together.
- Output gating: z0..z5 = lane registers ANDed with rnd_valid, so z is all-zero whenever rnd_valid=0.
- FSM states:
  - UNSEEDED: seed_ready=0. Moves to SEED on the next cycle.
  - SEED: seed_ready=1. Each seed_valid&&seed_ready beat loads lane[k] with k = beat counter 0..5.
    - A zero seed word is replaced by 32'h00000001 to avoid LFSR lock-up.
    - After beat 5, go to FILL.
  - FILL: one cycle; all lanes step; use counter cleared; reseed_req=0. Go to READY.
  - READY: rnd_valid=1.
    - rnd_req=1: set consumed; go to REFILL; use counter increments, saturating at RESEED_INTERVAL.
    - flush=1 (without rnd_req): go to REFILL; counter unchanged.
  - REFILL: rnd_valid=0; all lanes step; go to READY. Exception: optional-feature gating applies.
- Latency:
  - Back-to-back consumption yields one fresh set every 2 cycles: consume in cycle t, rnd_valid=0 at t+1, next set valid at t+2.
  - First set valid 2 cycles after the sixth seed beat (FILL, then READY).
- Simultaneous events in READY:
  - rnd_req and flush together count as a consume.
  - rnd_req while rnd_valid=0 is ignored.
  - seed_valid outside SEED is ignored.
- Reseed request: reseed_req=1 while use counter == RESEED_INTERVAL.
- Reseed entry: seed_valid asserted in READY when reseed_req=1 moves the FSM to SEED. That cycle's word is not consumed; seed_ready is low.
- Reseed completion: the FSM runs SEED and then FILL, which clears the counter and drops reseed_req.
- Lanes are never zero after seeding. A 32-step update of a nonzero state is nonzero.

Optional Feature:
- Macro: FRV_MASKED_RNG_RESEED_EN.
- Defined: in REFILL with use counter == RESEED_INTERVAL, the FSM goes to STALL instead of READY.
  - STALL: rnd_valid=0, seed_ready=0. Leaves for SEED on seed_valid.
  - No randomness is delivered past the interval.
- Undefined: reseed_req is advisory only; delivery continues indefinitely. STALL is not built.

Test Plan:
- Reset, then seeds 1,2,3,4,5,6 -> seed_ready high for exactly 6 accepted beats; rnd_valid=1 two cycles later; each z_k equals the 32-step model of (k+1).
- Seed words all zero -> every lane behaves as if seeded with 32'h00000001; z0==z1==...==z5, all nonzero.
- rnd_req held high for 10 cycles -> exactly 5 consumes; rnd_valid toggles 1,0,1,0...; no two consecutive sets are equal.
- RESEED_INTERVAL=4, consume 4 sets -> reseed_req=1 after the 4th. With FRV_MASKED_RNG_RESEED_EN: rnd_valid stays 0 until 6 new seed beats. Without it: 5th set delivered.
- flush in READY -> rnd_valid 0 for 1 cycle, new set differs from old, use counter unchanged.
- g_resetn=0 after beat 3 of seeding -> all outputs 0; next seeding restarts at lane 0.

Source files
------------

// File: rtl/frv_masked_rng_bank.sv
// frv_masked_rng_bank: six-lane 32-bit Galois LFSR randomness bank feeding the
// z0..z5 inputs of the masked Boolean ALU wrapper. Lanes are seeded one word per
// beat and advanced by 32 Galois iterations per step. Each set is presented once,
// and a reseed is requested after RESEED_INTERVAL consumed sets.
// Optional feature macro: FRV_MASKED_RNG_RESEED_EN. When it is defined, delivery
// stalls once the interval is reached and resumes only after a fresh seed.
module frv_masked_rng_bank #(
  parameter int                   BIT_WIDTH       = 32,
  parameter int                   RESEED_INTERVAL = 1024,
  parameter logic [BIT_WIDTH-1:0] LFSR_MASK       = 32'h80200003
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 flush,
  input  logic                 seed_valid,
  input  logic [BIT_WIDTH-1:0] seed,
  output logic                 seed_ready,
  input  logic                 rnd_req,
  output logic                 rnd_valid,
  output logic [BIT_WIDTH-1:0] z0,
  output logic [BIT_WIDTH-1:0] z1,
  output logic [BIT_WIDTH-1:0] z2,
  output logic [BIT_WIDTH-1:0] z3,
  output logic [BIT_WIDTH-1:0] z4,
  output logic [BIT_WIDTH-1:0] z5,
  output logic                 reseed_req
);

  localparam int          NUM_LANES = 6;
  localparam logic [15:0] INTERVAL  = 16'(RESEED_INTERVAL);
  localparam logic [2:0]  LAST_BEAT = 3'd5;

`ifdef FRV_MASKED_RNG_RESEED_EN
  typedef enum logic [2:0] {
    ST_UNSEEDED, ST_SEED, ST_FILL, ST_READY, ST_REFILL, ST_STALL
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_UNSEEDED, ST_SEED, ST_FILL, ST_READY, ST_REFILL
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] lane_q [NUM_LANES];
  logic [2:0]           beat_q;
  logic [15:0]          use_q;

  logic                 load_en;
  logic                 step_en;
  logic                 cnt_clr;
  logic                 cnt_inc;
  logic                 reseed_hit;
  logic [BIT_WIDTH-1:0] seed_fixed;

  // One lane update: BIT_WIDTH unrolled Galois iterations. A nonzero state
  // never maps to zero, so seeded lanes stay alive.
  function automatic logic [BIT_WIDTH-1:0] lfsr_step(input logic [BIT_WIDTH-1:0] s_in);
    logic [BIT_WIDTH-1:0] s;
    s = s_in;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      s = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    end
    return s;
  endfunction

  // An all-zero seed would lock a lane at zero forever, so it is replaced with 1.
  assign seed_fixed = (seed == '0) ? BIT_WIDTH'(1) : seed;
  assign reseed_hit = (use_q == INTERVAL);

  // Status outputs decode directly from the state; FILL hides the stale count.
  assign seed_ready = (state_q == ST_SEED);
  assign rnd_valid  = (state_q == ST_READY);
  assign reseed_req = reseed_hit && (state_q != ST_FILL);

  // Randomness is forced to zero whenever no fresh set is being presented.
  assign z0 = lane_q[0] & {BIT_WIDTH{rnd_valid}};
  assign z1 = lane_q[1] & {BIT_WIDTH{rnd_valid}};
  assign z2 = lane_q[2] & {BIT_WIDTH{rnd_valid}};
  assign z3 = lane_q[3] & {BIT_WIDTH{rnd_valid}};
  assign z4 = lane_q[4] & {BIT_WIDTH{rnd_valid}};
  assign z5 = lane_q[5] & {BIT_WIDTH{rnd_valid}};

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    load_en = 1'b0;
    step_en = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_UNSEEDED: state_d = ST_SEED;
      ST_SEED: begin
        if (seed_valid) begin
          load_en = 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        step_en = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_READY;
      end
      ST_READY: begin
        // A consume wins over flush and over a reseed attempt in the same cycle.
        if (rnd_req) begin
          cnt_inc = 1'b1;
          state_d = ST_REFILL;
        end else if (flush) begin
          state_d = ST_REFILL;
        end else if (seed_valid && reseed_hit) begin
          state_d = ST_SEED;
        end
      end
      ST_REFILL: begin
        step_en = 1'b1;
        state_d = ST_READY;
`ifdef FRV_MASKED_RNG_RESEED_EN
        if (reseed_hit) state_d = ST_STALL;
`endif
      end
`ifdef FRV_MASKED_RNG_RESEED_EN
      ST_STALL: begin
        if (seed_valid) state_d = ST_SEED;
      end
`endif
      default: state_d = ST_UNSEEDED;
    endcase
  end

  // State register, seed-beat counter and saturating use counter.
  always_ff @(posedge g_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!g_resetn) begin
      state_q <= ST_UNSEEDED;
      beat_q  <= '0;
      use_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_en) begin
        beat_q <= (beat_q == LAST_BEAT) ? 3'd0 : beat_q + 3'd1;
      end
      if (cnt_clr) begin
        use_q <= '0;
      end else if (cnt_inc && !reseed_hit) begin
        use_q <= use_q + 16'd1;
      end
    end
  end

  // Lane registers: load one lane per seed beat, or step all six together.
  always_ff @(posedge g_clk) begin
    // NOTE: the lane bank is only six words, so it is reset as ordinary flops rather than treated as an unreset memory.
    if (!g_resetn) begin
      for (int k = 0; k < NUM_LANES; k++) lane_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (load_en && (beat_q == 3'(k))) begin
          lane_q[k] <= seed_fixed;
        end else if (step_en) begin
          lane_q[k] <= lfsr_step(lane_q[k]);
        end
      end
    end
  end

endmodule

// File: tb/tb_frv_masked_rng_bank.sv
// Directed bench for frv_masked_rng_bank. The DUT is built with a short
// reseed interval so that the reseed boundary is reached quickly. The bench
// follows FRV_MASKED_RNG_RESEED_EN the same way the RTL does.
module tb_frv_masked_rng_bank;

  localparam int          TB_INTERVAL = 6;
  localparam logic [31:0] MASK        = 32'h80200003;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        flush;
  logic        seed_valid;
  logic [31:0] seed;
  logic        rnd_req;
  logic        seed_ready;
  logic        rnd_valid;
  logic        reseed_req;
  logic [31:0] z0, z1, z2, z3, z4, z5;

  logic [31:0] z      [6];
  logic [31:0] m_lane [6];
  logic [31:0] words  [6];
  logic [31:0] prev   [6];

  int n_pass  = 0;
  int n_total = 0;

  assign z[0] = z0;
  assign z[1] = z1;
  assign z[2] = z2;
  assign z[3] = z3;
  assign z[4] = z4;
  assign z[5] = z5;

  always #5 g_clk = ~g_clk;

  frv_masked_rng_bank #(
    .BIT_WIDTH      (32),
    .RESEED_INTERVAL(TB_INTERVAL),
    .LFSR_MASK      (MASK)
  ) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .flush      (flush),
    .seed_valid (seed_valid),
    .seed       (seed),
    .seed_ready (seed_ready),
    .rnd_req    (rnd_req),
    .rnd_valid  (rnd_valid),
    .z0         (z0),
    .z1         (z1),
    .z2         (z2),
    .z3         (z3),
    .z4         (z4),
    .z5         (z5),
    .reseed_req (reseed_req)
  );

  // Reference lane update: 32 Galois shifts with the feedback mask.
  function automatic logic [31:0] mstep(input logic [31:0] s_in);
    logic [31:0] s;
    s = s_in;
    for (int i = 0; i < 32; i++) begin
      if (s[0]) s = (s >> 1) ^ MASK;
      else      s = s >> 1;
    end
    return s;
  endfunction

  function automatic logic [31:0] fixz(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  // Feed n words from words[], then for a full load check FILL and the first set.
  task automatic load_seed(input int n);
    int waited;
    waited = 0;
    while (seed_ready !== 1'b1 && waited < 20) begin
      tick;
      waited++;
    end
    n_total++;
    if (seed_ready !== 1'b1) $display("FAIL seed_ready_wait: got %b want 1", seed_ready);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (seed_ready !== 1'b1) $display("FAIL seed_ready_beat%0d: got %b want 1", i, seed_ready);
      else n_pass++;
      seed_valid = 1'b1;
      seed       = words[i];
      tick;
    end
    seed_valid = 1'b0;
    seed       = 32'd0;
    if (n == 6) begin
      n_total++;
      if ({seed_ready, rnd_valid} !== 2'b00)
        $display("FAIL fill_cycle: got ready/valid=%b want 00", {seed_ready, rnd_valid});
      else n_pass++;
      for (int k = 0; k < 6; k++) m_lane[k] = mstep(fixz(words[k]));
      tick;
      n_total++;
      if (rnd_valid !== 1'b1) $display("FAIL first_set_valid: got %b want 1", rnd_valid);
      else n_pass++;
      for (int k = 0; k < 6; k++) begin
        n_total++;
        if (z[k] !== m_lane[k]) $display("FAIL first_set_z%0d: got %h want %h", k, z[k], m_lane[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic apply_reset;
    g_resetn   = 1'b0;
    flush      = 1'b0;
    seed_valid = 1'b0;
    seed       = 32'd0;
    rnd_req    = 1'b0;
    tick;
    tick;
    g_resetn   = 1'b1;
  endtask

  task automatic test_reset;
    g_resetn = 1'b0;
    tick;
    tick;
    n_total++;
    if ({rnd_valid, seed_ready, reseed_req} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {rnd_valid, seed_ready, reseed_req});
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (z[k] !== 32'd0) $display("FAIL reset_z%0d: got %h want 0", k, z[k]);
      else n_pass++;
    end
    g_resetn = 1'b1;
  endtask

  task automatic test_seed_basic;
    for (int k = 0; k < 6; k++) words[k] = 32'(k + 1);
    load_seed(6);
    n_total++;
    if (reseed_req !== 1'b0) $display("FAIL seed_basic_reseed: got %b want 0", reseed_req);
    else n_pass++;
  endtask

  task automatic test_flush;
    for (int k = 0; k < 6; k++) prev[k] = z[k];
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n_total++;
    if (rnd_valid !== 1'b0) $display("FAIL flush_gap_valid: got %b want 0", rnd_valid);
    else n_pass++;
    n_total++;
    if (z0 !== 32'd0) $display("FAIL flush_gap_z0: got %h want 0", z0);
    else n_pass++;
    for (int k = 0; k < 6; k++) m_lane[k] = mstep(m_lane[k]);
    tick;
    n_total++;
    if (rnd_valid !== 1'b1) $display("FAIL flush_new_valid: got %b want 1", rnd_valid);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (z[k] !== m_lane[k] || z[k] === prev[k])
        $display("FAIL flush_new_z%0d: got %h want %h (old %h)", k, z[k], m_lane[k], prev[k]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic exp_valid;
    int   consumes;
    exp_valid = 1'b1;
    consumes  = 0;
    rnd_req   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_total++;
      if (rnd_valid !== exp_valid) $display("FAIL b2b_valid_c%0d: got %b want %b", c, rnd_valid, exp_valid);
      else n_pass++;
      if (rnd_valid === 1'b1) consumes++;
      if (exp_valid) begin
        n_total++;
        if (z0 !== m_lane[0] || z5 !== m_lane[5])
          $display("FAIL b2b_set_c%0d: got z0=%h z5=%h want %h %h", c, z0, z5, m_lane[0], m_lane[5]);
        else n_pass++;
        if (c > 0) begin
          n_total++;
          if (z0 === prev[0]) $display("FAIL b2b_repeat_c%0d: got z0=%h equal to previous", c, z0);
          else n_pass++;
        end
        prev[0] = z0;
        for (int k = 0; k < 6; k++) m_lane[k] = mstep(m_lane[k]);
      end
      exp_valid = ~exp_valid;
      tick;
    end
    rnd_req = 1'b0;
    n_total++;
    if (consumes != 5) $display("FAIL b2b_consumes: got %0d want 5", consumes);
    else n_pass++;
    n_total++;
    if (reseed_req !== 1'b0) $display("FAIL b2b_reseed: got %b want 0", reseed_req);
    else n_pass++;
  endtask

  // Five sets consumed so far (the flush did not count); the sixth hits the interval.
  task automatic test_reseed;
    n_total++;
    if (rnd_valid !== 1'b1) $display("FAIL reseed_pre_valid: got %b want 1", rnd_valid);
    else n_pass++;
    rnd_req = 1'b1;
    tick;
    rnd_req = 1'b0;
    for (int k = 0; k < 6; k++) m_lane[k] = mstep(m_lane[k]);
    n_total++;
    if ({reseed_req, rnd_valid} !== 2'b10)
      $display("FAIL reseed_assert: got req/valid=%b want 10", {reseed_req, rnd_valid});
    else n_pass++;
    tick;
`ifdef FRV_MASKED_RNG_RESEED_EN
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if ({rnd_valid, seed_ready, reseed_req} !== 3'b001)
        $display("FAIL stall_c%0d: got valid/ready/req=%b want 001", c, {rnd_valid, seed_ready, reseed_req});
      else n_pass++;
      tick;
    end
`else
    n_total++;
    if (rnd_valid !== 1'b1 || z0 !== m_lane[0] || reseed_req !== 1'b1)
      $display("FAIL advisory_set: got valid=%b z0=%h req=%b want 1 %h 1", rnd_valid, z0, reseed_req, m_lane[0]);
    else n_pass++;
`endif
    seed_valid = 1'b1;
    seed       = 32'hDEAD_BEEF;
    n_total++;
    if (seed_ready !== 1'b0) $display("FAIL reseed_entry_ready: got %b want 0", seed_ready);
    else n_pass++;
    tick;
    seed_valid = 1'b0;
    seed       = 32'd0;
    words[0] = 32'h1234_5678; words[1] = 32'h0BAD_F00D; words[2] = 32'hCAFE_0001;
    words[3] = 32'h0000_0000; words[4] = 32'h8000_0000; words[5] = 32'hFFFF_FFFF;
    load_seed(6);
    n_total++;
    if (reseed_req !== 1'b0) $display("FAIL reseed_cleared: got %b want 0", reseed_req);
    else n_pass++;
  endtask

  task automatic test_reset_mid_seed;
    apply_reset;
    for (int k = 0; k < 6; k++) words[k] = 32'hA000_0000 + 32'(k);
    load_seed(3);
    g_resetn = 1'b0;
    tick;
    n_total++;
    if ({rnd_valid, seed_ready, reseed_req} !== 3'b000 || z0 !== 32'd0)
      $display("FAIL mid_seed_reset: got flags=%b z0=%h want 000 0", {rnd_valid, seed_ready, reseed_req}, z0);
    else n_pass++;
    g_resetn = 1'b1;
    for (int k = 0; k < 6; k++) words[k] = 32'h0000_0100 << k;
    load_seed(6);
  endtask

  task automatic test_zero_seed;
    apply_reset;
    for (int k = 0; k < 6; k++) words[k] = 32'd0;
    load_seed(6);
    for (int k = 1; k < 6; k++) begin
      n_total++;
      if (z[k] !== z0) $display("FAIL zero_seed_equal_z%0d: got %h want %h", k, z[k], z0);
      else n_pass++;
    end
    n_total++;
    if (z0 === 32'd0) $display("FAIL zero_seed_nonzero: got %h want nonzero", z0);
    else n_pass++;
  endtask

  initial begin
    g_resetn   = 1'b0;
    flush      = 1'b0;
    seed_valid = 1'b0;
    seed       = 32'd0;
    rnd_req    = 1'b0;
    test_reset;
    test_seed_basic;
    test_flush;
    test_back_to_back;
    test_reseed;
    test_reset_mid_seed;
    test_zero_seed;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
